data_memory_unit: RTL and testbench

Executes the data-memory access requested by the decoded `memory_rw`/`memory_type` control pair of a load or store instruction. It sits between the pipeline's memory stage and the word-wide data bus. It converts byte, halfword and word requests into aligned bus transactions with byte strobes, then returns sign- or zero-extended load data. It runs one request at a time through a request/response handshake, with misalignment and bus-timeout error reporting.

---
 rtl/data_memory_unit.sv | 126 ++++++++++++
 tb/tb_data_memory_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// data_memory_unit: load/store unit turning byte/half/word requests into aligned word-bus transactions
module data_memory_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  memory_rw,
  input  logic [3:0]  memory_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] load_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  localparam logic [1:0] M_X = 2'b00, M_R = 2'b01, M_W = 2'b10, M_ILL = 2'b11;
  localparam logic [3:0] MT_B = 4'd1, MT_H = 4'd2, MT_W = 4'd3, MT_BU = 4'd4, MT_HU = 4'd5;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t      state_q;
  logic [3:0]  type_q;
  logic [1:0]  lane_q;
  logic [31:0] cnt_q;
  logic        resp_valid_q, resp_err_q, bus_req_q, bus_we_q;
  logic [31:0] load_data_q, bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_wstrb_q;
  logic        is_w, is_r, type_ok, mis, err_d, go_bus_d, timeout_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d, shifted, ld_d;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign load_data  = load_data_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign bus_wdata  = bus_wdata_q;
  // classify the incoming request and build write lanes; extract load data from the bus word
  always_comb begin
    is_w      = (memory_rw == M_W);
    is_r      = (memory_rw == M_R);
    type_ok   = is_w ? (memory_type inside {MT_B, MT_H, MT_W}) : (memory_type inside {MT_B, MT_H, MT_W, MT_BU, MT_HU});
    mis       = ((memory_type == MT_H || memory_type == MT_HU) && addr[0]) || (memory_type == MT_W && addr[1:0] != 2'b00);
    err_d     = (memory_rw == M_ILL) || (memory_rw != M_X && (!type_ok || mis));
    go_bus_d  = (is_r || is_w) && !err_d;
    wstrb_d   = !is_w ? 4'b0000 : memory_type == MT_B ? 4'b0001 << addr[1:0] : memory_type == MT_H ? 4'b0011 << addr[1:0] : 4'b1111;
    wdata_d   = !is_w ? 32'd0 : memory_type == MT_B ? {4{store_data[7:0]}} : memory_type == MT_H ? {2{store_data[15:0]}} : store_data;
    shifted   = bus_rdata >> {lane_q, 3'b000};
    byte_v    = shifted[7:0];
    half_v    = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ld_d      = bus_we_q ? 32'd0 :
                type_q == MT_B  ? {{24{byte_v[7]}}, byte_v} :
                type_q == MT_BU ? {24'd0, byte_v} :
                type_q == MT_H  ? {{16{half_v[15]}}, half_v} :
                type_q == MT_HU ? {16'd0, half_v} :
                type_q == MT_W  ? bus_rdata : 32'd0;
    timeout_d = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 32'd1);
  end
  // request FSM with registered bus and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      type_q       <= 4'd0;
      lane_q       <= 2'd0;
      cnt_q        <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      load_data_q  <= 32'd0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_wstrb_q  <= 4'd0;
      bus_wdata_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          type_q <= memory_type;
          lane_q <= addr[1:0];
          cnt_q  <= 32'd0;
          if (go_bus_d) begin
            state_q     <= BUS;
            bus_req_q   <= 1'b1;
            bus_we_q    <= is_w;
            bus_addr_q  <= {addr[31:2], 2'b00};
            bus_wstrb_q <= wstrb_d;
            bus_wdata_q <= wdata_d;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_d;
            load_data_q  <= 32'd0;
          end
        end
        BUS: if (bus_ack || timeout_d) begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= !bus_ack;
          load_data_q  <= bus_ack ? ld_d : 32'd0;
          bus_req_q    <= 1'b0;
          bus_we_q     <= 1'b0;
          bus_wstrb_q  <= 4'd0;
          bus_wdata_q  <= 32'd0;
        end else begin
          cnt_q <= cnt_q + 32'd1;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          load_data_q  <= 32'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: directed vectors with a response scoreboard for data_memory_unit
module tb_data_memory_unit;
  logic        clk = 0, reset = 1, req_valid = 0, req_ready;
  logic [1:0]  memory_rw = 0;
  logic [3:0]  memory_type = 0;
  logic [31:0] addr = 0, store_data = 0;
  logic        resp_valid, resp_err, bus_req, bus_we, bus_ack = 0;
  logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata = 0;
  logic [3:0]  bus_wstrb;
  int          checks = 0, errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] e;

  data_memory_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .memory_rw(memory_rw), .memory_type(memory_type), .addr(addr), .store_data(store_data),
    .resp_valid(resp_valid), .resp_err(resp_err), .load_data(load_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask

  // scoreboard monitor: every response pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        e = exp_q.pop_front();
        chk("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
        chk("load_data", load_data, e[31:0]);
      end
    end
  end

  task automatic issue(input logic [1:0] rw, input logic [3:0] t, input logic [31:0] a, input logic [31:0] sd,
                       input logic push, input logic x_err, input logic [31:0] x_data);
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("ready_wait", {31'd0, req_ready}, 32'd1);
    if (push) exp_q.push_back({x_err, x_data});
    memory_rw = rw; memory_type = t; addr = a; store_data = sd; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic bus_xact(input int dly, input logic [31:0] rd, input logic we,
                          input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd);
    for (int i = 0; i <= dly; i++) begin
      chk("bus_req", {31'd0, bus_req}, 32'd1);
      chk("bus_we", {31'd0, bus_we}, {31'd0, we});
      chk("bus_addr", bus_addr, a);
      chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, st});
      if (we) chk("bus_wdata", bus_wdata, wd);
      if (i < dly) begin @(posedge clk); #1; end
    end
    bus_ack = 1; bus_rdata = rd;
    @(posedge clk); #1;
    bus_ack = 0; bus_rdata = 32'hA5A5_5A5A;
    chk("bus_req_drop", {31'd0, bus_req}, 32'd0);
  endtask

  task automatic nobus(input logic [1:0] rw, input logic [3:0] t, input logic [31:0] a, input logic x_err);
    issue(rw, t, a, 32'hFFFF_FFFF, 1, x_err, 32'd0);
    chk("nobus_req", {31'd0, bus_req}, 32'd0);
    chk("nobus_resp_cycle1", {31'd0, resp_valid}, 32'd1);
    @(posedge clk); #1;
    chk("nobus_req_after", {31'd0, bus_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int n;
    #2;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    // LB / LBU from lane 3
    issue(2'b01, 4'd1, 32'h1003, 0, 1, 0, 32'hFFFF_FF80);
    bus_xact(2, 32'h80FF_1234, 0, 32'h1000, 4'b0000, 0);
    issue(2'b01, 4'd4, 32'h1003, 0, 1, 0, 32'h0000_0080);
    bus_xact(2, 32'h80FF_1234, 0, 32'h1000, 4'b0000, 0);
    // SH to upper half
    issue(2'b10, 4'd2, 32'h2002, 32'hDEAD_BEEF, 1, 0, 32'd0);
    bus_xact(2, 32'h0, 1, 32'h2000, 4'b1100, 32'hBEEF_BEEF);
    // SB lane 1, LHU upper half, LW
    issue(2'b10, 4'd1, 32'h2101, 32'h0000_00C3, 1, 0, 32'd0);
    bus_xact(0, 32'h0, 1, 32'h2100, 4'b0010, 32'hC3C3_C3C3);
    issue(2'b01, 4'd5, 32'h2102, 0, 1, 0, 32'h0000_9ABC);
    bus_xact(1, 32'h9ABC_1111, 0, 32'h2100, 4'b0000, 0);
    issue(2'b01, 4'd3, 32'h2104, 0, 1, 0, 32'hCAFE_F00D);
    bus_xact(0, 32'hCAFE_F00D, 0, 32'h2104, 4'b0000, 0);
    // no-bus paths: misaligned, illegal, M_X
    nobus(2'b01, 4'd3, 32'h3001, 1);
    nobus(2'b01, 4'd5, 32'h3003, 1);
    nobus(2'b11, 4'd3, 32'h3000, 1);
    nobus(2'b10, 4'd4, 32'h3000, 1);
    nobus(2'b01, 4'd7, 32'h3000, 1);
    nobus(2'b00, 4'd0, 32'h3000, 0);
    // timeout with no ack
    issue(2'b01, 4'd3, 32'h40, 0, 1, 1, 32'd0);
    n = 0;
    while (bus_req && n < 20) begin n++; @(posedge clk); #1; end
    chk("timeout_len", n, 32'd4);
    chk("timeout_resp", {31'd0, resp_valid}, 32'd1);
    // ack on the last allowed cycle wins over timeout
    issue(2'b01, 4'd3, 32'h44, 0, 1, 0, 32'h1234_5678);
    bus_xact(3, 32'h1234_5678, 0, 32'h44, 4'b0000, 0);
    // reset in the middle of a bus transaction
    issue(2'b01, 4'd3, 32'h50, 0, 0, 0, 32'd0);
    chk("abort_bus_req", {31'd0, bus_req}, 32'd1);
    @(posedge clk); #2;
    reset = 1;
    #1;
    chk("async_rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("late_ack_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("late_ack_no_bus", {31'd0, bus_req}, 32'd0);
    end
    bus_ack = 0;
    // back-to-back SW then LH with req_valid held
    exp_q.push_back({1'b0, 32'd0});
    exp_q.push_back({1'b0, 32'hFFFF_8765});
    memory_rw = 2'b10; memory_type = 4'd3; addr = 32'h60; store_data = 32'h1234_8765; req_valid = 1;
    @(posedge clk); #1;
    chk("b2b_sw_req", {31'd0, bus_req}, 32'd1);
    chk("b2b_sw_strb", {28'd0, bus_wstrb}, 32'hF);
    chk("b2b_sw_wdata", bus_wdata, 32'h1234_8765);
    bus_ack = 1; memory_rw = 2'b01; memory_type = 4'd2;
    @(posedge clk); #1;
    bus_ack = 0;
    chk("b2b_not_ready_c2", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_ready_c3", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 0;
    chk("b2b_lh_req", {31'd0, bus_req}, 32'd1);
    chk("b2b_lh_we", {31'd0, bus_we}, 32'd0);
    chk("b2b_lh_addr", bus_addr, 32'h60);
    bus_ack = 1; bus_rdata = 32'h1234_8765;
    @(posedge clk); #1;
    bus_ack = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin n++; @(posedge clk); #1; end
    chk("scoreboard_drain", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
